steel_dmem_responder: RTL and testbench
=======================================

Name: steel_dmem_responder

Overview:
- Data-memory responder for the steel_top data port. Answers the core's D_ADDR/DATA_OUT/WR_REQ/WR_MASK requests and returns DATA_IN.
- Word-organised RAM behind a one-entry store buffer. Read data is registered, with byte-merge bypass from the pending store.
- Instantiated in design_top in place of the tied-off DATA_IN. It makes load/store sequences observable for SQED formal runs.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- ADDR_W, $clog2(DEPTH_WORDS), word-index width (localparam, derived).

Ports:
- CLK  input  1  single clock, rising-edge.
- RESET  input  1  asynchronous, active-low reset.
- D_ADDR  input  32  byte address from core.
- DATA_OUT  input  32  store data from core.
- WR_REQ  input  1  store request, sampled every cycle.
- WR_MASK  input  4  byte-lane enables; bit i covers DATA_OUT[8i+7:8i].
- DATA_IN  output  32  registered load data to core.
- ADDR_ERR  output  1  registered flag: previous cycle's address was out of range.

Behaviour:
- Address decode:
  - off = D_ADDR - BASE_ADDR.
  - in_range = (D_ADDR >= BASE_ADDR) && (off < 4*DEPTH_WORDS).
  - idx = off[ADDR_W+1:2]; D_ADDR[1:0] ignored.
- Reset (RESET low, asynchronous):
  - DATA_IN = 0, ADDR_ERR = 0, pb_valid = 0.
  - A pending store is discarded, never committed.
  - RAM contents are not reset.
- Store capture, cycle N: if WR_REQ && in_range && WR_MASK != 0, then pb_idx <= idx, pb_data <= DATA_OUT, pb_mask <= WR_MASK, pb_valid <= 1. Otherwise pb_valid <= 0 after commit.
- Commit, edge ending cycle N+1: if pb_valid, write RAM[pb_idx] byte lanes where pb_mask=1. Untouched lanes keep their value.
- Back-to-back stores: the old entry commits and the new entry is captured on the same edge. No stall, no loss.
- Load, every cycle: DATA_IN <= merge(RAM[idx], pb) at the rising edge, visible in cycle N+1 (latency 1).
  - merge: lane i = pb_data lane i if pb_valid && pb_idx==idx && pb_mask[i]; else RAM lane i.
- Read-first: a store issued in cycle N is NOT visible in DATA_IN for a load of the same address in cycle N. It is visible from a load in cycle N+1 onward, via the bypass or via RAM.
- DATA_IN is updated every cycle, including cycles with WR_REQ=1.
- Out of range:
  - Store dropped; pb_valid <= 0 after committing any existing entry.
  - DATA_IN <= 0; ADDR_ERR <= 1 for one cycle.
- In-range access: ADDR_ERR <= 0.
- WR_REQ=1 with WR_MASK=0: treated as a load only; no buffer entry.
- Wrap-around: no aliasing; addresses at or above BASE+4*DEPTH are out of range, never wrapped.
- Write path latency 2 edges to RAM; architectural visibility 1 cycle via the bypass.

Optional Feature:
- Macro: STEEL_DMEM_ERR_CNT_EN.
- Defined:
  - Adds output ERR_CNT [15:0], reset 0.
  - Increments on each cycle with !in_range.
  - Saturates at 16'hFFFF; cleared only by RESET.
- Undefined: no port, no counter logic. ADDR_ERR behaviour is identical in both builds.

Decomposition:
- Package steel_dmem_pkg:
  - WORD_W=32, MASK_W=4.
  - typedef pbuf_t {valid, idx, data, mask}.
  - function byte_merge(base, new, mask).
- One sub-module, steel_dmem_store_buf: holds the pbuf_t register, capture/commit control, and the bypass merge.
- RAM array and address decode stay in the top.

Test Plan:
- Store 32'hDEADBEEF, mask 4'hF @0x10 in cycle 0; load 0x10 in cycle 1 -> DATA_IN=32'hDEADBEEF in cycle 2 (bypass). Same load in cycle 5 -> 32'hDEADBEEF (RAM).
- RAM[4]=32'h11223344. Store 32'hAABBCCDD mask 4'b0101 @0x10; next load -> 32'h11BB33DD.
- Back-to-back stores @0x20: 32'h000000AA mask 0001, then 32'hBB000000 mask 1000; load in next cycle -> lanes 0 and 3 = AA/BB, middle lanes unchanged.
- Same-cycle store and load @0x30, old value 32'h5 -> DATA_IN=32'h5 next cycle. Load in the following cycle returns the new data.
- Load @BASE+4*DEPTH -> DATA_IN=0, ADDR_ERR=1 for exactly one cycle. Store there leaves all RAM words unchanged. With STEEL_DMEM_ERR_CNT_EN, ERR_CNT increments by 1.
- Store @0x40, assert RESET low in the next cycle before commit; after release, load 0x40 -> prior value. DATA_IN=0 and ADDR_ERR=0 while in reset.

Source files
------------

// File: rtl/steel_dmem_pkg.sv
// Shared types and helpers for the steel data-memory responder.
// Holds the store-buffer entry type and the byte-lane merge function.
package steel_dmem_pkg;

  localparam int WORD_W    = 32;
  localparam int MASK_W    = 4;
  localparam int IDX_MAX_W = 30;

  // idx is sized for the largest possible word index; narrower RAMs zero-extend into it
  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] idx;
    logic [WORD_W-1:0]    data;
    logic [MASK_W-1:0]    mask;
  } pbuf_t;

  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] base,
    input logic [WORD_W-1:0] wdata,
    input logic [MASK_W-1:0] mask
  );
    logic [WORD_W-1:0] res;
    res = base;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/steel_dmem_store_buf.sv
// One-entry store buffer: captures a store, commits it to RAM one edge later,
// and merges its pending bytes into read data for the same word.
module steel_dmem_store_buf
  import steel_dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en,
  input  logic [ADDR_W-1:0] cap_idx,
  input  logic [WORD_W-1:0] cap_data,
  input  logic [MASK_W-1:0] cap_mask,
  input  logic [ADDR_W-1:0] rd_idx,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic [WORD_W-1:0] bypass_data,
  output logic              commit_en,
  output logic [ADDR_W-1:0] commit_idx,
  output logic [WORD_W-1:0] commit_data,
  output logic [MASK_W-1:0] commit_mask
);

  pbuf_t pb_q;
  pbuf_t pb_d;
  logic  hit;

  always_comb begin
    pb_d = pb_q;
    if (cap_en) begin
      pb_d.valid = 1'b1;
      pb_d.idx   = IDX_MAX_W'(cap_idx);
      pb_d.data  = cap_data;
      pb_d.mask  = cap_mask;
    end else begin
      pb_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pb_q <= '0;
    else        pb_q <= pb_d;
  end

  // The entry commits on the same edge a new one may be captured, so back-to-back stores never stall
  always_comb begin
    commit_en   = pb_q.valid;
    commit_idx  = pb_q.idx[ADDR_W-1:0];
    commit_data = pb_q.data;
    commit_mask = pb_q.mask;
  end

  always_comb begin
    hit         = pb_q.valid && (pb_q.idx == IDX_MAX_W'(rd_idx));
    bypass_data = hit ? byte_merge(ram_rdata, pb_q.data, pb_q.mask) : ram_rdata;
  end

endmodule

// File: rtl/steel_dmem_responder.sv
// Data-memory responder for the steel core: word RAM behind a one-entry store buffer,
// registered read-first loads. Define STEEL_DMEM_ERR_CNT_EN to add the ERR_CNT output.
module steel_dmem_responder
  import steel_dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       D_ADDR,
  input  logic [WORD_W-1:0] DATA_OUT,
  input  logic              WR_REQ,
  input  logic [MASK_W-1:0] WR_MASK,
  output logic [WORD_W-1:0] DATA_IN,
  output logic              ADDR_ERR
`ifdef STEEL_DMEM_ERR_CNT_EN
  ,
  output logic [15:0]       ERR_CNT
`endif
);

  localparam int          ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;

  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              cap_en;
  logic [WORD_W-1:0] ram_rdata;
  logic [WORD_W-1:0] bypass_data;
  logic              commit_en;
  logic [ADDR_W-1:0] commit_idx;
  logic [WORD_W-1:0] commit_data;
  logic [MASK_W-1:0] commit_mask;

  logic [WORD_W-1:0] data_in_q, data_in_d;
  logic              addr_err_q, addr_err_d;

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // 33-bit span compare keeps the top of the address space from wrapping into range
  always_comb begin
    off      = D_ADDR - BASE_ADDR;
    in_range = (D_ADDR >= BASE_ADDR) && ({1'b0, off} < SPAN);
    idx      = off[ADDR_W+1:2];
    cap_en   = WR_REQ && in_range && (WR_MASK != '0);
  end

  assign ram_rdata = mem[idx];

  steel_dmem_store_buf #(
    .ADDR_W (ADDR_W)
  ) u_store_buf (
    .clk         (CLK),
    .rst_n       (RESET),
    .cap_en      (cap_en),
    .cap_idx     (idx),
    .cap_data    (DATA_OUT),
    .cap_mask    (WR_MASK),
    .rd_idx      (idx),
    .ram_rdata   (ram_rdata),
    .bypass_data (bypass_data),
    .commit_en   (commit_en),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_mask (commit_mask)
  );

  always_ff @(posedge CLK) begin
    if (commit_en) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (commit_mask[i]) mem[commit_idx][8*i +: 8] <= commit_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    data_in_d  = in_range ? bypass_data : '0;
    addr_err_d = !in_range;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_in_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      data_in_q  <= data_in_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign DATA_IN  = data_in_q;
  assign ADDR_ERR = addr_err_q;

`ifdef STEEL_DMEM_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (!in_range && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_steel_dmem_responder.sv
// Directed, table-driven bench for steel_dmem_responder (default parameters).
// Build with STEEL_DMEM_ERR_CNT_EN defined to also check the error counter.
module tb_steel_dmem_responder;

  logic        CLK;
  logic        RESET;
  logic [31:0] D_ADDR;
  logic [31:0] DATA_OUT;
  logic        WR_REQ;
  logic [3:0]  WR_MASK;
  logic [31:0] DATA_IN;
  logic        ADDR_ERR;
`ifdef STEEL_DMEM_ERR_CNT_EN
  logic [15:0] ERR_CNT;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  mask;
    logic        chk;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  steel_dmem_responder dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .D_ADDR   (D_ADDR),
    .DATA_OUT (DATA_OUT),
    .WR_REQ   (WR_REQ),
    .WR_MASK  (WR_MASK),
    .DATA_IN  (DATA_IN),
    .ADDR_ERR (ADDR_ERR)
`ifdef STEEL_DMEM_ERR_CNT_EN
    ,
    .ERR_CNT  (ERR_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void add_vec(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic wr, input logic [3:0] mask, input logic chk,
                                  input logic [31:0] exp_data, input logic exp_err);
    vec_t v;
    v = '{addr, wdata, wr, mask, chk, exp_data, exp_err};
    vecs.push_back(v);
  endfunction

  // Drives one request for one cycle and returns #1 after the edge that registers it
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic wr, input logic [3:0] mask);
    D_ADDR   = addr;
    DATA_OUT = wdata;
    WR_REQ   = wr;
    WR_MASK  = mask;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_data, input logic exp_err);
    n_vec++;
    if (DATA_IN !== exp_data || ADDR_ERR !== exp_err) begin
      n_fail++;
      $display("[TB] FAIL %s: got DATA_IN=%h ADDR_ERR=%b, required DATA_IN=%h ADDR_ERR=%b",
               name, DATA_IN, ADDR_ERR, exp_data, exp_err);
    end
  endtask

`ifdef STEEL_DMEM_ERR_CNT_EN
  task automatic checkErrCnt(input string name, input logic [15:0] exp_cnt);
    n_vec++;
    if (ERR_CNT !== exp_cnt) begin
      n_fail++;
      $display("[TB] FAIL %s: got ERR_CNT=%0d, required %0d", name, ERR_CNT, exp_cnt);
    end
  endtask
`endif

  initial begin
    // addr, wdata, wr, mask, chk, exp_data, exp_err
    add_vec(32'h10,   32'hDEADBEEF, 1, 4'hF, 0, 32'h0,        0);
    add_vec(32'h10,   32'h0,        0, 4'h0, 1, 32'hDEADBEEF, 0);
    add_vec(32'h10,   32'h0,        0, 4'h0, 1, 32'hDEADBEEF, 0);
    add_vec(32'h10,   32'h0,        0, 4'h0, 1, 32'hDEADBEEF, 0);
    add_vec(32'h10,   32'h0,        0, 4'h0, 1, 32'hDEADBEEF, 0);
    add_vec(32'h10,   32'h11223344, 1, 4'hF, 1, 32'hDEADBEEF, 0);
    add_vec(32'h10,   32'hAABBCCDD, 1, 4'h5, 1, 32'h11223344, 0);
    add_vec(32'h10,   32'h0,        0, 4'h0, 1, 32'h11BB33DD, 0);
    add_vec(32'h10,   32'h0,        0, 4'h0, 1, 32'h11BB33DD, 0);
    add_vec(32'h20,   32'h12345678, 1, 4'hF, 0, 32'h0,        0);
    add_vec(32'h20,   32'h000000AA, 1, 4'h1, 1, 32'h12345678, 0);
    add_vec(32'h20,   32'hBB000000, 1, 4'h8, 1, 32'h123456AA, 0);
    add_vec(32'h20,   32'h0,        0, 4'h0, 1, 32'hBB3456AA, 0);
    add_vec(32'h20,   32'h0,        0, 4'h0, 1, 32'hBB3456AA, 0);
    add_vec(32'h30,   32'h00000005, 1, 4'hF, 0, 32'h0,        0);
    add_vec(32'h30,   32'h0,        0, 4'h0, 1, 32'h00000005, 0);
    add_vec(32'h30,   32'hCAFEF00D, 1, 4'hF, 1, 32'h00000005, 0);
    add_vec(32'h30,   32'h0,        0, 4'h0, 1, 32'hCAFEF00D, 0);
    add_vec(32'h1000, 32'h0,        0, 4'h0, 1, 32'h0,        1);
    add_vec(32'h30,   32'h0,        0, 4'h0, 1, 32'hCAFEF00D, 0);
    add_vec(32'h1000, 32'hFFFFFFFF, 1, 4'hF, 1, 32'h0,        1);
    add_vec(32'h10,   32'h0,        0, 4'h0, 1, 32'h11BB33DD, 0);
    add_vec(32'h20,   32'h0,        0, 4'h0, 1, 32'hBB3456AA, 0);
    add_vec(32'h30,   32'h0,        0, 4'h0, 1, 32'hCAFEF00D, 0);
    add_vec(32'h30,   32'h0000FFFF, 1, 4'h3, 1, 32'hCAFEF00D, 0);
    add_vec(32'h1010, 32'h0,        1, 4'hF, 1, 32'h0,        1);
    add_vec(32'h30,   32'h0,        0, 4'h0, 1, 32'hCAFEFFFF, 0);
    add_vec(32'h10,   32'h0,        0, 4'h0, 1, 32'h11BB33DD, 0);
    add_vec(32'h20,   32'h0,        1, 4'h0, 1, 32'hBB3456AA, 0);
    add_vec(32'h20,   32'h0,        0, 4'h0, 1, 32'hBB3456AA, 0);
    add_vec(32'h23,   32'h0,        0, 4'h0, 1, 32'hBB3456AA, 0);

    RESET    = 1'b0;
    D_ADDR   = 32'h0;
    DATA_OUT = 32'h0;
    WR_REQ   = 1'b0;
    WR_MASK  = 4'h0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_state", 32'h0, 1'b0);
`ifdef STEEL_DMEM_ERR_CNT_EN
    checkErrCnt("reset_errcnt", 16'd0);
`endif
    RESET = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].mask);
      if (vecs[i].chk) checkOutput($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_err);
    end

`ifdef STEEL_DMEM_ERR_CNT_EN
    checkErrCnt("errcnt_after_vectors", 16'd3);
`endif

    // A store still in the buffer when reset asserts must never reach RAM
    applyStimulus(32'h40, 32'h13579BDF, 1, 4'hF);
    applyStimulus(32'h40, 32'h0, 0, 4'h0);
    checkOutput("bypass_40", 32'h13579BDF, 1'b0);
    applyStimulus(32'h40, 32'h0, 1, 4'hF);
    checkOutput("pre_reset_40", 32'h13579BDF, 1'b0);
    RESET  = 1'b0;
    WR_REQ = 1'b0;
    #1;
    checkOutput("in_reset_async", 32'h0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("in_reset_held", 32'h0, 1'b0);
    RESET = 1'b1;
    applyStimulus(32'h40, 32'h0, 0, 4'h0);
    checkOutput("after_reset_40", 32'h13579BDF, 1'b0);

    applyStimulus(32'h1000, 32'h0, 0, 4'h0);
    checkOutput("err_before_reset", 32'h0, 1'b1);
    RESET = 1'b0;
    #1;
    checkOutput("err_cleared_by_reset", 32'h0, 1'b0);
`ifdef STEEL_DMEM_ERR_CNT_EN
    checkErrCnt("errcnt_cleared", 16'd0);
`endif
    #3;
    RESET = 1'b1;
    applyStimulus(32'h40, 32'h0, 0, 4'h0);
    checkOutput("final_40", 32'h13579BDF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
